// File: rtl/closest_hit_resolve_if.sv
// Intersect-result stream in, resolved closest-hit result out, plus sticky error flags.
interface closest_hit_resolve_if #(
    parameter int TOTAL_PREC  = 27,
    parameter int TRI_ID_BITS = 8
);
    logic                          in_valid;
    logic                          in_first;
    logic                          in_last;
    logic [TRI_ID_BITS-1:0]        in_tri_id;
    logic                          in_hit;
    logic signed [TOTAL_PREC-1:0]  in_oa;
    logic signed [TOTAL_PREC-1:0]  in_t;
    logic                          out_valid;
    logic                          out_ready;
    logic                          out_hit;
    logic [TRI_ID_BITS-1:0]        out_tri_id;
    logic signed [TOTAL_PREC-1:0]  out_oa;
    logic signed [TOTAL_PREC-1:0]  out_t;
    logic                          overflow;
    logic                          proto_err;

    // master: intersect pipeline plus result consumer; slave: the resolver
    modport master (
        output in_valid, in_first, in_last, in_tri_id, in_hit, in_oa, in_t, out_ready,
        input  out_valid, out_hit, out_tri_id, out_oa, out_t, overflow, proto_err
    );
    modport slave (
        input  in_valid, in_first, in_last, in_tri_id, in_hit, in_oa, in_t, out_ready,
        output out_valid, out_hit, out_tri_id, out_oa, out_t, overflow, proto_err
    );
endinterface

// File: rtl/closest_hit_resolve.sv
// Per-ray closest-hit reduction: picks the smallest t/oa among hit samples of a
// first..last framed ray using cross-multiplication, and holds the result for a consumer.
module closest_hit_resolve #(
    parameter int TOTAL_PREC  = 27,
    parameter int FRAC_BITS   = 22,
    parameter int TRI_ID_BITS = 8
) (
    input logic                  clk,
    input logic                  rst,
    closest_hit_resolve_if.slave bus
);
    localparam int PW = 2 * TOTAL_PREC;

    if (FRAC_BITS >= TOTAL_PREC) begin : g_frac_chk
        $error("FRAC_BITS must be smaller than TOTAL_PREC");
    end

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                        r_state;
    logic                          r_s1_valid, r_s1_first, r_s1_last, r_s1_hit;
    logic [TRI_ID_BITS-1:0]        r_s1_id;
    logic signed [TOTAL_PREC-1:0]  r_s1_oa, r_s1_t;
    logic                          r_best_hit;
    logic [TRI_ID_BITS-1:0]        r_best_id;
    logic signed [TOTAL_PREC-1:0]  r_best_oa, r_best_t;
    logic                          r_out_valid, r_out_hit;
    logic [TRI_ID_BITS-1:0]        r_out_id;
    logic signed [TOTAL_PREC-1:0]  r_out_oa, r_out_t;
    logic                          r_overflow, r_perr;

    logic signed [PW-1:0]          w_tc, w_oab, w_tb, w_oac, w_lhs, w_rhs;
    logic                          w_cand, w_better, w_take, w_accept, w_resolve;
    logic                          w_perr_evt, w_load;
    logic                          w_fin_hit;
    logic [TRI_ID_BITS-1:0]        w_fin_id;
    logic signed [TOTAL_PREC-1:0]  w_fin_oa, w_fin_t;

    // Full-width products: t_c*oa_b < t_b*oa_c  <=>  t_c/oa_c < t_b/oa_b for positive oa
    assign w_tc  = {{TOTAL_PREC{r_s1_t[TOTAL_PREC-1]}},    r_s1_t};
    assign w_oab = {{TOTAL_PREC{r_best_oa[TOTAL_PREC-1]}}, r_best_oa};
    assign w_tb  = {{TOTAL_PREC{r_best_t[TOTAL_PREC-1]}},  r_best_t};
    assign w_oac = {{TOTAL_PREC{r_s1_oa[TOTAL_PREC-1]}},   r_s1_oa};
    assign w_lhs = w_tc * w_oab;
    assign w_rhs = w_tb * w_oac;

    always_comb begin
        w_cand     = r_s1_hit && !r_s1_oa[TOTAL_PREC-1] && (r_s1_oa != '0);
        w_better   = !r_best_hit || (w_lhs < w_rhs);
        w_take     = w_cand && (r_s1_first || w_better);
        w_accept   = r_s1_valid && (r_s1_first || (r_state == ACCUM));
        w_resolve  = w_accept && r_s1_last;
        w_perr_evt = r_s1_valid && (r_s1_first == (r_state == ACCUM));
        w_load     = w_resolve && (!r_out_valid || bus.out_ready);
        // A first sample restarts the ray, so a non-candidate one yields an all-zero best
        w_fin_hit  = r_best_hit;
        w_fin_id   = r_best_id;
        w_fin_oa   = r_best_oa;
        w_fin_t    = r_best_t;
        if (w_take) begin
            w_fin_hit = 1'b1;
            w_fin_id  = r_s1_id;
            w_fin_oa  = r_s1_oa;
            w_fin_t   = r_s1_t;
        end else if (r_s1_first) begin
            w_fin_hit = 1'b0;
            w_fin_id  = '0;
            w_fin_oa  = '0;
            w_fin_t   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_s1_valid  <= 1'b0;
            r_s1_first  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_hit    <= 1'b0;
            r_s1_id     <= '0;
            r_s1_oa     <= '0;
            r_s1_t      <= '0;
            r_best_hit  <= 1'b0;
            r_best_id   <= '0;
            r_best_oa   <= '0;
            r_best_t    <= '0;
            r_out_valid <= 1'b0;
            r_out_hit   <= 1'b0;
            r_out_id    <= '0;
            r_out_oa    <= '0;
            r_out_t     <= '0;
            r_overflow  <= 1'b0;
            r_perr      <= 1'b0;
        end else begin
            r_s1_valid <= bus.in_valid;
            r_s1_first <= bus.in_first;
            r_s1_last  <= bus.in_last;
            r_s1_hit   <= bus.in_hit;
            r_s1_id    <= bus.in_tri_id;
            r_s1_oa    <= bus.in_oa;
            r_s1_t     <= bus.in_t;

            if (w_accept) begin
                r_state    <= r_s1_last ? IDLE : ACCUM;
                r_best_hit <= w_fin_hit;
                r_best_id  <= w_fin_id;
                r_best_oa  <= w_fin_oa;
                r_best_t   <= w_fin_t;
            end

            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_hit   <= w_fin_hit;
                r_out_id    <= w_fin_id;
                r_out_oa    <= w_fin_oa;
                r_out_t     <= w_fin_t;
            end else begin
                if (w_resolve)
                    r_overflow <= 1'b1;
                if (r_out_valid && bus.out_ready)
                    r_out_valid <= 1'b0;
            end

            if (w_perr_evt)
                r_perr <= 1'b1;
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.out_hit    = r_out_hit;
    assign bus.out_tri_id = r_out_id;
    assign bus.out_oa     = r_out_oa;
    assign bus.out_t      = r_out_t;
    assign bus.overflow   = r_overflow;
    assign bus.proto_err  = r_perr;
endmodule

// File: tb/tb_closest_hit_resolve.sv
// Directed table plus hand-written sequences and a small random run for closest_hit_resolve.
module tb_closest_hit_resolve;
    localparam int W    = 27;
    localparam int IDB  = 8;
    localparam int ONE  = 4194304;
    localparam int MAXP = 67108863;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    closest_hit_resolve_if #(.TOTAL_PREC(W), .TRI_ID_BITS(IDB)) bus ();
    closest_hit_resolve #(.TOTAL_PREC(W), .FRAC_BITS(22), .TRI_ID_BITS(IDB)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct {
        logic f, l; logic [7:0] id; logic h; int oa, t;
        logic ev, eh; logic [7:0] eid; int eoa, et;
    } vec_t;

    typedef struct { logic h; logic [7:0] id; int oa, t; } res_t;

    int total = 0;
    int bad   = 0;
    vec_t tv[14];
    res_t exp_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic v, input logic h,
                           input logic [7:0] id, input int oa, input int t);
        chk({nm, "_valid"}, bus.out_valid, v);
        if (v) begin
            chk({nm, "_hit"}, bus.out_hit, h);
            chk({nm, "_id"},  bus.out_tri_id, id);
            chk({nm, "_oa"},  bus.out_oa, oa);
            chk({nm, "_t"},   bus.out_t, t);
        end
    endtask

    task automatic drive(input logic v, input logic f, input logic l, input logic [7:0] id,
                         input logic h, input int oa, input int t);
        bus.in_valid  = v;
        bus.in_first  = f;
        bus.in_last   = l;
        bus.in_tri_id = id;
        bus.in_hit    = h;
        bus.in_oa     = W'(oa);
        bus.in_t      = W'(t);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 0, 0);
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic mon();
        res_t e;
        if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
                chk("rnd_extra", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk_out("rnd", 1'b1, e.h, e.id, e.oa, e.t);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.in_last = 1'b0;
        bus.in_tri_id = '0; bus.in_hit = 1'b0; bus.in_oa = '0; bus.in_t = '0;
        bus.out_ready = 1'b1;

        //             f     l     id     h     oa        t         ev    eh    eid    eoa       et
        tv[0]  = '{1'b1, 1'b0, 8'd0,  1'b1, ONE,      2*ONE,    1'b0, 1'b0, 8'd0,  0,        0};
        tv[1]  = '{1'b0, 1'b0, 8'd1,  1'b1, 2*ONE,    3*ONE,    1'b0, 1'b0, 8'd0,  0,        0};
        tv[2]  = '{1'b0, 1'b1, 8'd2,  1'b0, 0,        0,        1'b1, 1'b1, 8'd1,  2*ONE,    3*ONE};
        tv[3]  = '{1'b1, 1'b0, 8'd3,  1'b1, ONE,      ONE,      1'b0, 1'b0, 8'd0,  0,        0};
        tv[4]  = '{1'b0, 1'b1, 8'd4,  1'b1, 2*ONE,    2*ONE,    1'b1, 1'b1, 8'd3,  ONE,      ONE};
        tv[5]  = '{1'b1, 1'b1, 8'd5,  1'b1, 0,        ONE,      1'b1, 1'b0, 8'd0,  0,        0};
        tv[6]  = '{1'b1, 1'b0, 8'd6,  1'b1, -ONE,     -ONE,     1'b0, 1'b0, 8'd0,  0,        0};
        tv[7]  = '{1'b0, 1'b1, 8'd7,  1'b1, ONE,      5*ONE,    1'b1, 1'b1, 8'd7,  ONE,      5*ONE};
        tv[8]  = '{1'b1, 1'b0, 8'd8,  1'b1, ONE,      -ONE,     1'b0, 1'b0, 8'd0,  0,        0};
        tv[9]  = '{1'b0, 1'b1, 8'd9,  1'b1, ONE,      ONE,      1'b1, 1'b1, 8'd8,  ONE,      -ONE};
        tv[10] = '{1'b1, 1'b0, 8'd10, 1'b1, MAXP,     MAXP,     1'b0, 1'b0, 8'd0,  0,        0};
        tv[11] = '{1'b0, 1'b1, 8'd11, 1'b1, MAXP-1,   MAXP-2,   1'b1, 1'b1, 8'd11, MAXP-1,   MAXP-2};
        tv[12] = '{1'b1, 1'b0, 8'd12, 1'b0, ONE,      ONE,      1'b0, 1'b0, 8'd0,  0,        0};
        tv[13] = '{1'b0, 1'b1, 8'd13, 1'b0, ONE,      ONE,      1'b1, 1'b0, 8'd0,  0,        0};

        // Reset state
        @(posedge clk); #1;
        chk_out("rst", 1'b0, 1'b0, 8'd0, 0, 0);
        chk("rst_hit", bus.out_hit, 1'b0);
        chk("rst_id", bus.out_tri_id, 8'd0);
        chk("rst_t", bus.out_t, 0);
        chk("rst_ovf", bus.overflow, 1'b0);
        chk("rst_perr", bus.proto_err, 1'b0);
        rst = 1'b0;

        // Table: result of row i-1 is visible after row i has been clocked in
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, tv[i].f, tv[i].l, tv[i].id, tv[i].h, tv[i].oa, tv[i].t);
            if (i > 0)
                chk_out($sformatf("tv%0d", i-1), tv[i-1].ev, tv[i-1].eh, tv[i-1].eid,
                        tv[i-1].eoa, tv[i-1].et);
        end
        idle();
        chk_out("tv13", tv[13].ev, tv[13].eh, tv[13].eid, tv[13].eoa, tv[13].et);
        idle();
        chk("tv_clear", bus.out_valid, 1'b0);
        chk("tv_ovf", bus.overflow, 1'b0);
        chk("tv_perr", bus.proto_err, 1'b0);

        // Back-to-back rays with consumer stalled
        bus.out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 8'd20, 1'b1, ONE, 2*ONE);
        drive(1'b1, 1'b0, 1'b1, 8'd21, 1'b1, ONE, ONE);
        drive(1'b1, 1'b1, 1'b1, 8'd22, 1'b1, ONE, ONE/4);
        chk_out("ovf_first", 1'b1, 1'b1, 8'd21, ONE, ONE);
        chk("ovf_pre", bus.overflow, 1'b0);
        idle();
        chk("ovf_set", bus.overflow, 1'b1);
        chk_out("ovf_hold", 1'b1, 1'b1, 8'd21, ONE, ONE);
        idle();
        chk_out("ovf_hold2", 1'b1, 1'b1, 8'd21, ONE, ONE);
        bus.out_ready = 1'b1;
        idle();
        chk("ovf_hs", bus.out_valid, 1'b0);

        // Asynchronous reset in the middle of an open ray
        bus.out_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 8'd30, 1'b1, ONE, ONE);
        idle();
        chk("mr_held", bus.out_valid, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 8'd0, 1'b1, ONE, ONE);
        #2 rst = 1'b1;
        #1;
        chk("mr_valid", bus.out_valid, 1'b0);
        chk("mr_hit", bus.out_hit, 1'b0);
        chk("mr_id", bus.out_tri_id, 8'd0);
        chk("mr_oa", bus.out_oa, 0);
        chk("mr_t", bus.out_t, 0);
        chk("mr_ovf", bus.overflow, 1'b0);
        chk("mr_perr", bus.proto_err, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 8'd1, 1'b1, ONE, ONE);
        idle();
        chk("mr_drop", bus.out_valid, 1'b0);
        chk("mr_perr_set", bus.proto_err, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 8'd7, 1'b1, ONE, 2*ONE);
        drive(1'b1, 1'b0, 1'b1, 8'd8, 1'b0, ONE, ONE);
        idle();
        chk_out("mr_new", 1'b1, 1'b1, 8'd7, ONE, 2*ONE);

        // Framing violations: stray sample in IDLE, then in_first mid-ray
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 8'd9, 1'b1, ONE, ONE);
        idle();
        chk("pe_idle_drop", bus.out_valid, 1'b0);
        chk("pe_idle_flag", bus.proto_err, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 8'd1, 1'b1, ONE, ONE);
        drive(1'b1, 1'b1, 1'b0, 8'd2, 1'b1, ONE, 4*ONE);
        drive(1'b1, 1'b0, 1'b1, 8'd3, 1'b1, ONE, 3*ONE);
        chk("pe_abandon", bus.out_valid, 1'b0);
        idle();
        chk_out("pe_new", 1'b1, 1'b1, 8'd3, ONE, 3*ONE);
        idle();
        chk("pe_once", bus.out_valid, 1'b0);

        // Random rays at full rate against a division-based model
        do_reset();
        begin
            int nexp = 0;
            int nray = 0;
            for (int r = 0; r < 25; r++) begin
                int len;
                logic bh;
                logic [7:0] bid;
                int boa, bt;
                len = int'($urandom_range(1, 16));
                bh = 1'b0; bid = '0; boa = 0; bt = 0;
                for (int s = 0; s < len; s++) begin
                    logic h, cand, f, l;
                    logic [7:0] id;
                    int oa, t;
                    h  = ($urandom_range(0, 9) < 7);
                    oa = int'($urandom_range(0, 300)) - 40;
                    t  = int'($urandom_range(0, 2000)) - 500;
                    id = 8'(nray * 16 + s);
                    f  = (s == 0);
                    l  = (s == len - 1);
                    cand = h && (oa > 0);
                    if (f) begin
                        bh = cand;
                        bid = cand ? id : 8'd0; boa = cand ? oa : 0; bt = cand ? t : 0;
                    end else if (cand && (!bh || ($itor(t) / $itor(oa) < $itor(bt) / $itor(boa)))) begin
                        bh = 1'b1; bid = id; boa = oa; bt = t;
                    end
                    if (l) begin
                        exp_q.push_back('{bh, bid, boa, bt});
                        nexp++;
                    end
                    drive(1'b1, f, l, id, h, oa, t);
                    mon();
                end
                nray++;
            end
            for (int k = 0; k < 3; k++) begin
                idle();
                mon();
            end
            chk("rnd_count", exp_q.size(), 0);
            chk("rnd_ovf", bus.overflow, 1'b0);
            chk("rnd_perr", bus.proto_err, 1'b0);
            if (nexp == 0) chk("rnd_nexp", 1'b0, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
